// File: rtl/tipi_pkg.sv
// Shared constants, FSM state type and captured-bus payload for the TIPI register block.
package tipi_pkg;

  localparam logic [15:0] ADDR_TD    = 16'h5FFF;
  localparam logic [15:0] ADDR_TC    = 16'h5FFD;
  localparam logic [15:0] ADDR_RD    = 16'h5FFB;
  localparam logic [15:0] ADDR_RC    = 16'h5FF9;
  localparam logic [3:0]  CRU_PREFIX = 4'h1;

  typedef enum logic {
    RST_IDLE  = 1'b0,
    RST_PULSE = 1'b1
  } rst_state_e;

  // Bus sample delayed alongside the synchronised strobes
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        sdata;
  } bus_cap_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous strobe, with rise/fall pulses
// derived from one extra history flop.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o  = sync_q[STAGES-1];
  assign rise_c_o = level_o & ~prev_q;
  assign fall_c_o = ~level_o & prev_q;

endmodule

// File: rtl/tipi_bus_regs.sv
// TIPI bus register block: TD/TC write latches, RD/RC serial assembly, CRU bit
// bank, DSR read path and timed RPi reset pulse, all in the clk domain.
module tipi_bus_regs
  import tipi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CRU_BITS        = 4,
  parameter int unsigned RESET_PULSE_CYC = 50000,
  parameter int unsigned SHIFT_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [0:15]         ti_a,
  input  logic [0:7]          ti_data,
  input  logic                ti_memen,
  input  logic                ti_we,
  input  logic                ti_dbin,
  input  logic                ti_cruclk,
  input  logic [3:0]          cru_base,
  input  logic                rpi_dclk,
  input  logic                rpi_cclk,
  input  logic                rpi_sdata,
  input  logic                rpi_le,
  output logic [7:0]          rpi_d,
  output logic [7:0]          rpi_s,
  output logic [0:7]          dsr_d,
  output logic                tipi_dbus_oe,
  output logic [CRU_BITS-1:0] cru_state,
  output logic                rpi_reset,
  output logic                frame_err
);

  localparam int unsigned CNT_W = $clog2(SHIFT_W + 2);
  localparam int unsigned PW    = (RESET_PULSE_CYC > 1) ? $clog2(RESET_PULSE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(SHIFT_W);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SHIFT_W + 1);
  localparam logic [PW-1:0]    PULSE_LOAD = PW'(RESET_PULSE_CYC - 1);

  logic we_lvl, we_rise, we_fall;
  logic memen_lvl, memen_rise, memen_fall;
  logic cruclk_lvl, cruclk_rise, cruclk_fall;
  logic dclk_lvl, dclk_rise, dclk_fall;
  logic cclk_lvl, cclk_rise, cclk_fall;
  logic le_lvl, le_rise, le_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_we (
    .clk(clk), .rst_n(rst_n), .d_i(ti_we),
    .level_o(we_lvl), .rise_c_o(we_rise), .fall_c_o(we_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_memen (
    .clk(clk), .rst_n(rst_n), .d_i(ti_memen),
    .level_o(memen_lvl), .rise_c_o(memen_rise), .fall_c_o(memen_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cruclk (
    .clk(clk), .rst_n(rst_n), .d_i(ti_cruclk),
    .level_o(cruclk_lvl), .rise_c_o(cruclk_rise), .fall_c_o(cruclk_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dclk (
    .clk(clk), .rst_n(rst_n), .d_i(rpi_dclk),
    .level_o(dclk_lvl), .rise_c_o(dclk_rise), .fall_c_o(dclk_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cclk (
    .clk(clk), .rst_n(rst_n), .d_i(rpi_cclk),
    .level_o(cclk_lvl), .rise_c_o(cclk_rise), .fall_c_o(cclk_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_le (
    .clk(clk), .rst_n(rst_n), .d_i(rpi_le),
    .level_o(le_lvl), .rise_c_o(le_rise), .fall_c_o(le_fall));

  logic unused_sync;
  assign unused_sync = ^{we_lvl, we_rise, memen_rise, memen_fall, cruclk_lvl, cruclk_rise,
                         dclk_lvl, dclk_fall, cclk_lvl, cclk_fall, le_lvl, le_fall};

  // Bus pipeline matched to the strobe synchroniser depth
  bus_cap_t                        cap_in_c, cap_c;
  bus_cap_t [SYNC_STAGES-1:0]      cap_q;

  assign cap_in_c.addr  = ti_a;
  assign cap_in_c.data  = ti_data;
  assign cap_in_c.sdata = rpi_sdata;
  assign cap_c          = cap_q[SYNC_STAGES-1];

  logic [7:0]          rpi_d_q, rpi_d_d, rpi_s_q, rpi_s_d;
  logic [7:0]          rd_q, rd_d, rc_q, rc_d;
  logic [CRU_BITS-1:0] cru_state_q, cru_state_d;
  logic                frame_err_q, frame_err_d;
  logic [SHIFT_W-1:0]  shd_q, shd_d, shc_q, shc_d;
  logic [CNT_W-1:0]    cntd_q, cntd_d, cntc_q, cntc_d;
  logic                cru_hit_c;
  logic                req_c, req_prev_q, req_rise_c;
  rst_state_e          st_q, st_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic                rpi_reset_q, rpi_reset_d;

  always_comb begin
    rpi_d_d     = rpi_d_q;
    rpi_s_d     = rpi_s_q;
    rd_d        = rd_q;
    rc_d        = rc_q;
    cru_state_d = cru_state_q;
    frame_err_d = frame_err_q;
    shd_d       = shd_q;
    shc_d       = shc_q;
    cntd_d      = cntd_q;
    cntc_d      = cntc_q;

    if (we_fall && !memen_lvl && cru_state_q[0]) begin
      if (cap_c.addr == ADDR_TD) begin
        rpi_d_d = cap_c.data;
      end else if (cap_c.addr == ADDR_TC) begin
        rpi_s_d = cap_c.data;
      end
    end

    cru_hit_c = cruclk_fall && (cap_c.addr[15:8] == {CRU_PREFIX, cru_base})
                && (32'(cap_c.addr[7:1]) < CRU_BITS);
    for (int i = 0; i < int'(CRU_BITS); i++) begin
      if (cru_hit_c && (cap_c.addr[7:1] == 7'(i))) cru_state_d[i] = cap_c.addr[0];
    end
    if (cru_hit_c && (cap_c.addr[7:1] == 7'd1) && cap_c.addr[0]) frame_err_d = 1'b0;

    if (dclk_rise) begin
      shd_d = {shd_q[SHIFT_W-2:0], cap_c.sdata};
      if (cntd_q != CNT_MAX) cntd_d = cntd_q + CNT_W'(1);
    end
    if (cclk_rise) begin
      shc_d = {shc_q[SHIFT_W-2:0], cap_c.sdata};
      if (cntc_q != CNT_MAX) cntc_d = cntc_q + CNT_W'(1);
    end

    // Commit uses pre-shift state; a coincident shift opens the next frame
    if (le_rise) begin
      if (cntd_q == CNT_FULL) rd_d = shd_q[7:0];
      else if (cntd_q != '0) frame_err_d = 1'b1;
      if (cntc_q == CNT_FULL) rc_d = shc_q[7:0];
      else if (cntc_q != '0) frame_err_d = 1'b1;
      cntd_d = dclk_rise ? CNT_W'(1) : '0;
      cntc_d = cclk_rise ? CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q       <= '0;
      rpi_d_q     <= '0;
      rpi_s_q     <= '0;
      rd_q        <= '0;
      rc_q        <= '0;
      cru_state_q <= '0;
      frame_err_q <= 1'b0;
      shd_q       <= '0;
      shc_q       <= '0;
      cntd_q      <= '0;
      cntc_q      <= '0;
    end else begin
      cap_q       <= {cap_q[SYNC_STAGES-2:0], cap_in_c};
      rpi_d_q     <= rpi_d_d;
      rpi_s_q     <= rpi_s_d;
      rd_q        <= rd_d;
      rc_q        <= rc_d;
      cru_state_q <= cru_state_d;
      frame_err_q <= frame_err_d;
      shd_q       <= shd_d;
      shc_q       <= shc_d;
      cntd_q      <= cntd_d;
      cntc_q      <= cntc_d;
    end
  end

  always_comb begin
    req_c = 1'b0;
    for (int i = 0; i < int'(CRU_BITS); i++) begin
      if (i == 1) req_c = cru_state_q[i];
    end
    req_rise_c = req_c & ~req_prev_q;
  end

  // Reset pulse: retrigger reloads, a held request does not extend
  always_comb begin
    st_d        = st_q;
    pcnt_d      = pcnt_q;
    rpi_reset_d = rpi_reset_q;
    case (st_q)
      RST_IDLE: begin
        if (req_rise_c) begin
          st_d        = RST_PULSE;
          pcnt_d      = PULSE_LOAD;
          rpi_reset_d = 1'b0;
        end
      end
      RST_PULSE: begin
        if (req_rise_c) begin
          pcnt_d = PULSE_LOAD;
        end else if (pcnt_q == '0) begin
          st_d        = RST_IDLE;
          rpi_reset_d = 1'b1;
        end else begin
          pcnt_d = pcnt_q - PW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= RST_IDLE;
      pcnt_q      <= '0;
      rpi_reset_q <= 1'b1;
      req_prev_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      pcnt_q      <= pcnt_d;
      rpi_reset_q <= rpi_reset_d;
      req_prev_q  <= req_c;
    end
  end

  // Read path straight from the pins so the bus transceiver turns on in-cycle
  always_comb begin
    tipi_dbus_oe = 1'b1;
    dsr_d        = '0;
    if (cru_state_q[0] && !ti_memen && ti_dbin) begin
      if (ti_a == ADDR_RD) begin
        tipi_dbus_oe = 1'b0;
        dsr_d        = rd_q;
      end else if (ti_a == ADDR_RC) begin
        tipi_dbus_oe = 1'b0;
        dsr_d        = rc_q;
      end
    end
  end

  assign rpi_d     = rpi_d_q;
  assign rpi_s     = rpi_s_q;
  assign cru_state = cru_state_q;
  assign frame_err = frame_err_q;
  assign rpi_reset = rpi_reset_q;

endmodule

// File: tb/tb_tipi_bus_regs.sv
// Self-checking bench for tipi_bus_regs: directed vectors and corner sequences,
// then random transactions against a transaction-level model.
module tb_tipi_bus_regs;

  localparam int unsigned SS  = 2;
  localparam int unsigned CB  = 4;
  localparam int unsigned RPC = 10;
  localparam int unsigned SW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:15]   ti_a;
  logic [0:7]    ti_data;
  logic          ti_memen, ti_we, ti_dbin, ti_cruclk;
  logic [3:0]    cru_base;
  logic          rpi_dclk, rpi_cclk, rpi_sdata, rpi_le;
  logic [7:0]    rpi_d, rpi_s;
  logic [0:7]    dsr_d;
  logic          tipi_dbus_oe;
  logic [CB-1:0] cru_state;
  logic          rpi_reset, frame_err;

  tipi_bus_regs #(
    .SYNC_STAGES(SS), .CRU_BITS(CB), .RESET_PULSE_CYC(RPC), .SHIFT_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ti_a(ti_a), .ti_data(ti_data),
    .ti_memen(ti_memen), .ti_we(ti_we), .ti_dbin(ti_dbin), .ti_cruclk(ti_cruclk),
    .cru_base(cru_base), .rpi_dclk(rpi_dclk), .rpi_cclk(rpi_cclk),
    .rpi_sdata(rpi_sdata), .rpi_le(rpi_le), .rpi_d(rpi_d), .rpi_s(rpi_s),
    .dsr_d(dsr_d), .tipi_dbus_oe(tipi_dbus_oe), .cru_state(cru_state),
    .rpi_reset(rpi_reset), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int low_cnt = 0;

  logic [7:0]    m_d, m_s, m_rd, m_rc;
  logic [CB-1:0] m_cru;
  logic          m_ferr;
  bit            m_qd[$];
  bit            m_qc[$];

  typedef struct {
    logic [15:0] addr;
    logic        memen;
    logic        dbin;
    logic        exp_oe;
    logic [7:0]  exp_dsr;
  } rd_vec_t;
  rd_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!rpi_reset) low_cnt++;
    end
  endtask

  task automatic drive_idle();
    ti_a = '0; ti_data = '0; ti_memen = 1'b1; ti_we = 1'b1; ti_dbin = 1'b0;
    ti_cruclk = 1'b1; cru_base = 4'h2;
    rpi_dclk = 1'b0; rpi_cclk = 1'b0; rpi_sdata = 1'b0; rpi_le = 1'b0;
  endtask

  task automatic model_reset();
    m_d = '0; m_s = '0; m_rd = '0; m_rc = '0; m_cru = '0; m_ferr = 1'b0;
    m_qd.delete(); m_qc.delete();
  endtask

  function automatic logic [7:0] frame_value(input bit q[$]);
    logic [7:0] v = '0;
    foreach (q[i]) v = {v[6:0], q[i]};
    return v;
  endfunction

  task automatic check_all(input string tag);
    check($sformatf("%s.rpi_d", tag), 32'(rpi_d), 32'(m_d));
    check($sformatf("%s.rpi_s", tag), 32'(rpi_s), 32'(m_s));
    check($sformatf("%s.cru_state", tag), 32'(cru_state), 32'(m_cru));
    check($sformatf("%s.frame_err", tag), 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic check_reset_vals(input string tag);
    check($sformatf("%s.rpi_d", tag), 32'(rpi_d), 32'h0);
    check($sformatf("%s.rpi_s", tag), 32'(rpi_s), 32'h0);
    check($sformatf("%s.dsr_d", tag), 32'(dsr_d), 32'h0);
    check($sformatf("%s.oe", tag), 32'(tipi_dbus_oe), 32'h1);
    check($sformatf("%s.cru_state", tag), 32'(cru_state), 32'h0);
    check($sformatf("%s.rpi_reset", tag), 32'(rpi_reset), 32'h1);
    check($sformatf("%s.frame_err", tag), 32'(frame_err), 32'h0);
  endtask

  task automatic ti_write(input logic [15:0] addr, input logic [7:0] data);
    ti_a = addr; ti_data = data; ti_memen = 1'b0; ti_we = 1'b0;
    tick(2);
    ti_we = 1'b1; ti_memen = 1'b1;
    tick(SS + 3);
    if (m_cru[0]) begin
      if (addr == 16'h5FFF) m_d = data;
      else if (addr == 16'h5FFD) m_s = data;
    end
  endtask

  task automatic cru_write(input logic [3:0] prefix, input logic [3:0] base,
                           input logic [6:0] k, input logic b);
    ti_a = {prefix, base, k, b}; ti_cruclk = 1'b0;
    tick(1);
    ti_cruclk = 1'b1;
    tick(SS + 3);
    if (prefix == 4'h1 && base == cru_base && 32'(k) < CB) begin
      m_cru[k] = b;
      if (k == 7'd1 && b) m_ferr = 1'b0;
    end
  endtask

  task automatic send_bits(input bit chan, input logic [15:0] value, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      rpi_sdata = value[i];
      if (chan) rpi_cclk = 1'b1; else rpi_dclk = 1'b1;
      tick(1);
      rpi_dclk = 1'b0; rpi_cclk = 1'b0;
      tick(1);
      if (chan) m_qc.push_back(value[i]); else m_qd.push_back(value[i]);
    end
    tick(SS + 1);
  endtask

  task automatic le_pulse();
    rpi_le = 1'b1;
    tick(1);
    rpi_le = 1'b0;
    tick(SS + 3);
    if (m_qd.size() == SW) m_rd = frame_value(m_qd);
    else if (m_qd.size() != 0) m_ferr = 1'b1;
    if (m_qc.size() == SW) m_rc = frame_value(m_qc);
    else if (m_qc.size() != 0) m_ferr = 1'b1;
    m_qd.delete(); m_qc.delete();
  endtask

  task automatic ti_read_check(input string tag, input logic [15:0] addr);
    logic       hit;
    logic [7:0] exp_dsr;
    ti_a = addr; ti_memen = 1'b0; ti_dbin = 1'b1;
    #1;
    hit     = m_cru[0] && (addr == 16'h5FFB || addr == 16'h5FF9);
    exp_dsr = !hit ? 8'h00 : (addr == 16'h5FFB ? m_rd : m_rc);
    check($sformatf("%s.oe@%h", tag, addr), 32'(tipi_dbus_oe), 32'(!hit));
    check($sformatf("%s.dsr@%h", tag, addr), 32'(dsr_d), 32'(exp_dsr));
    ti_memen = 1'b1; ti_dbin = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    tick(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick(2);

    // TD write latency, then TC write
    cru_write(4'h1, 4'h2, 7'd0, 1'b1);
    ti_a = 16'h5FFF; ti_data = 8'hA5; ti_memen = 1'b0; ti_we = 1'b0;
    tick(SS);
    check("td_early", 32'(rpi_d), 32'h00);
    tick(2);
    check("td_latency", 32'(rpi_d), 32'hA5);
    ti_we = 1'b1; ti_memen = 1'b1;
    tick(SS + 3);
    m_d = 8'hA5;
    ti_write(16'h5FFD, 8'h5A);
    check_all("tc_write");

    // Writes ignored while DSR disabled
    cru_write(4'h1, 4'h2, 7'd0, 1'b0);
    ti_write(16'h5FFF, 8'h11);
    check("td_disabled", 32'(rpi_d), 32'hA5);
    cru_write(4'h1, 4'h2, 7'd0, 1'b1);

    // RD and RC frames, read path table
    send_bits(1'b0, 16'h003C, 8);
    le_pulse();
    send_bits(1'b1, 16'h00C3, 8);
    le_pulse();
    vecs[0] = '{16'h5FFB, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[1] = '{16'h5FF9, 1'b0, 1'b1, 1'b0, 8'hC3};
    vecs[2] = '{16'h5FFA, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[3] = '{16'h5FFB, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[4] = '{16'h5FFB, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[5] = '{16'h5FFF, 1'b0, 1'b1, 1'b1, 8'h00};
    for (int i = 0; i < 6; i++) begin
      ti_a = vecs[i].addr; ti_memen = vecs[i].memen; ti_dbin = vecs[i].dbin;
      #1;
      check($sformatf("rdvec%0d.oe", i), 32'(tipi_dbus_oe), 32'(vecs[i].exp_oe));
      check($sformatf("rdvec%0d.dsr", i), 32'(dsr_d), 32'(vecs[i].exp_dsr));
    end
    ti_memen = 1'b1; ti_dbin = 1'b0;
    check("frames_ok.ferr", 32'(frame_err), 32'h0);

    // Short RC frame
    send_bits(1'b1, 16'h0015, 5);
    le_pulse();
    check("short.ferr", 32'(frame_err), 32'h1);
    ti_a = 16'h5FF9; ti_memen = 1'b0; ti_dbin = 1'b1;
    #1;
    check("short.rc_kept", 32'(dsr_d), 32'hC3);
    ti_memen = 1'b1; ti_dbin = 1'b0;

    // Bit1 write clears frame_err and starts one pulse
    cru_write(4'h1, 4'h2, 7'd1, 1'b0);
    low_cnt = 0;
    cru_write(4'h1, 4'h2, 7'd1, 1'b1);
    tick(20);
    check("pulse.ferr_clr", 32'(frame_err), 32'h0);
    check("pulse.len", 32'(low_cnt), 32'(RPC));

    // Retrigger five cycles into the pulse
    cru_write(4'h1, 4'h2, 7'd1, 1'b0);
    low_cnt = 0;
    ti_a = 16'h1203; ti_cruclk = 1'b0; tick(1);
    ti_cruclk = 1'b1; tick(1);
    ti_a = 16'h1202; ti_cruclk = 1'b0; tick(1);
    ti_cruclk = 1'b1; tick(2);
    ti_a = 16'h1203; ti_cruclk = 1'b0; tick(1);
    ti_cruclk = 1'b1; tick(30);
    m_cru[1] = 1'b1;
    check("retrig.len", 32'(low_cnt), 32'(RPC + 5));

    // Out-of-range bit and foreign base
    cru_write(4'h1, 4'h2, 7'(CB), 1'b1);
    check("cru_oor", 32'(cru_state), 32'h3);
    cru_write(4'h1, 4'h3, 7'd2, 1'b1);
    check("cru_base_mis", 32'(cru_state), 32'h3);
    check_all("cru_ignored");

    // Coincident latch and shift
    send_bits(1'b0, 16'h005A, 8);
    rpi_sdata = 1'b1; rpi_dclk = 1'b1; rpi_le = 1'b1;
    tick(1);
    rpi_dclk = 1'b0; rpi_le = 1'b0;
    tick(SS + 4);
    m_rd = 8'h5A; m_qd.delete(); m_qd.push_back(1'b1);
    ti_read_check("coinc1", 16'h5FFB);
    send_bits(1'b0, 16'h0025, 7);
    le_pulse();
    check("coinc2.model", 32'(m_rd), 32'hA5);
    ti_read_check("coinc2", 16'h5FFB);
    check_all("coinc2");

    // Reset mid-frame and mid-pulse
    send_bits(1'b0, 16'h0009, 4);
    cru_write(4'h1, 4'h2, 7'd1, 1'b0);
    cru_write(4'h1, 4'h2, 7'd1, 1'b1);
    check("midpulse.active", 32'(rpi_reset), 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    cru_write(4'h1, 4'h2, 7'd0, 1'b1);
    send_bits(1'b0, 16'h0096, 8);
    le_pulse();
    ti_read_check("post_rst", 16'h5FFB);
    check("post_rst.rd", 32'(m_rd), 32'h96);
    check_all("post_rst");

    // Random transactions against the model
    for (int it = 0; it < 80; it++) begin
      logic [15:0] a;
      int          op;
      op = int'($urandom_range(0, 5));
      case (op)
        0: begin
          case ($urandom_range(0, 3))
            0: a = 16'h5FFF;
            1: a = 16'h5FFD;
            2: a = 16'h5FFB;
            default: a = 16'($urandom);
          endcase
          ti_write(a, 8'($urandom));
        end
        1: cru_write(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h1,
                     ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h2,
                     7'($urandom_range(0, 5)), 1'($urandom));
        2, 3: send_bits(1'($urandom), 16'($urandom), int'($urandom_range(0, 10)));
        4: le_pulse();
        default: begin
          case ($urandom_range(0, 2))
            0: a = 16'h5FFB;
            1: a = 16'h5FF9;
            default: a = 16'($urandom);
          endcase
          ti_read_check("rnd_rd", a);
        end
      endcase
      check_all($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
